latch_sink: RTL and testbench

- Receiving end of the latch valid/ack output protocol. It consumes `out_vld`/`data_out` from a latch-style producer and returns the single-cycle `out_ack` pulse.
- Accepted words are buffered in a small FIFO and re-presented on a standard valid/ready stream toward downstream logic.
- Also keeps an accepted-word counter and a sticky protocol-error flag for bring-up and debug.

---
 rtl/latch_sink_if.sv | 21 ++
 rtl/latch_sink.sv | 88 ++++++++
 tb/tb_latch_sink.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/latch_sink_if.sv
// Handshake bundle for latch_sink: latch-style producer side plus the valid/ready stream side.
interface latch_sink_if #(
  parameter int unsigned DATA_W = 32
);
  logic              in_vld;
  logic [DATA_W-1:0] in_data;
  logic              in_ack;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;

  modport master (
    output in_vld, in_data, m_ready,
    input  in_ack, m_valid, m_data
  );

  modport slave (
    input  in_vld, in_data, m_ready,
    output in_ack, m_valid, m_data
  );
endinterface

// File: rtl/latch_sink.sv
// Receiver for the latch valid/ack protocol: acks each word once, buffers it in a FIFO
// and re-presents it on a valid/ready stream. Also keeps an accept counter and a sticky error flag.
module latch_sink #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  latch_sink_if.slave      bus,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             proto_err
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic {IDLE, WAIT_LOW} state_t;

  state_t            state_q;
  logic              in_ack_q;
  logic              vld_prev_q;
  logic              proto_err_q;
  logic [CNT_W-1:0]  count_q;
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PW-1:0] occ;
  logic          empty;
  logic          full_w;
  logic          push;
  logic          pop;

  // Pointers carry one extra wrap bit so occupancy DEPTH is distinguishable from empty.
  always_comb begin
    occ    = wr_ptr_q - rd_ptr_q;
    empty  = (occ == '0);
    full_w = (occ == PW'(DEPTH));
    push   = (state_q == IDLE) && bus.in_vld && !full_w;
    pop    = !empty && bus.m_ready;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q     <= IDLE;
      in_ack_q    <= 1'b0;
      vld_prev_q  <= 1'b0;
      proto_err_q <= 1'b0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      in_ack_q   <= 1'b0;
      vld_prev_q <= bus.in_vld;
      case (state_q)
        IDLE: begin
          if (push) begin
            in_ack_q <= 1'b1;
            state_q  <= WAIT_LOW;
          end
          // Only reachable with vld_prev_q high if the previous edge withheld the ack.
          if (vld_prev_q && !bus.in_vld) proto_err_q <= 1'b1;
        end
        WAIT_LOW: begin
          if (!bus.in_vld) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (push) begin
        count_q  <= count_q + CNT_W'(1);
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge ap_clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.in_data;
  end

  assign bus.in_ack  = in_ack_q;
  assign bus.m_valid = !empty;
  assign bus.m_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign count       = count_q;
  assign full        = full_w;
  assign proto_err   = proto_err_q;
endmodule

// File: tb/tb_latch_sink.sv
// Self-checking bench for latch_sink: directed protocol scenarios followed by a randomized phase,
// all checked every cycle against a queue-based protocol model.
module tb_latch_sink;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             proto_err;

  latch_sink_if #(.DATA_W(DATA_W)) bus ();

  latch_sink #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .ap_clk   (clk),
    .ap_rst   (rst),
    .bus      (bus),
    .count    (count),
    .full     (full),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Protocol model state
  logic [DATA_W-1:0] mq[$];
  int unsigned       m_cnt;
  bit                m_perr, m_acked, m_prev, m_ack;
  logic [DATA_W-1:0] got[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit push, pop;
    if (rst) begin
      mq.delete();
      m_cnt = 0; m_perr = 0; m_acked = 0; m_prev = 0; m_ack = 0;
    end else begin
      pop  = (mq.size() > 0) && bus.m_ready;
      push = !m_acked && bus.in_vld && (mq.size() < DEPTH);
      if (!m_acked && m_prev && !bus.in_vld) m_perr = 1;
      m_ack   = push;
      m_acked = m_acked ? bus.in_vld : push;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(bus.in_data);
      if (push) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      m_prev = bus.in_vld;
    end
  endtask

  task automatic cycle();
    if (bus.m_valid && bus.m_ready) got.push_back(bus.m_data);
    @(posedge clk);
    model_step();
    #1;
    check("in_ack", 64'(bus.in_ack), 64'(m_ack));
    check("m_valid", 64'(bus.m_valid), 64'(mq.size() > 0));
    check("count", 64'(count), 64'(m_cnt));
    check("full", 64'(full), 64'(mq.size() == DEPTH));
    check("proto_err", 64'(proto_err), 64'(m_perr));
    if (mq.size() > 0) check("m_data", 64'(bus.m_data), 64'(mq[0]));
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.in_vld = 1'b0; bus.m_ready = 1'b0; bus.in_data = '0;
    cycle(); cycle();
    rst = 1'b0;
  endtask

  task automatic send_word(input logic [DATA_W-1:0] d);
    bus.in_data = d; bus.in_vld = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (bus.in_ack) break;
    end
    check("send_ack", 64'(bus.in_ack), 64'(1));
    bus.in_vld = 1'b0;
    cycle();
  endtask

  initial begin
    int acks;
    logic [DATA_W-1:0] sent[$];
    bit seen_ack;
    bus.in_vld = 1'b0; bus.in_data = '0; bus.m_ready = 1'b0;

    // Reset values
    do_reset();
    cycle();
    check("rst_ack", 64'(bus.in_ack), 64'(0));
    check("rst_valid", 64'(bus.m_valid), 64'(0));
    check("rst_count", 64'(count), 64'(0));

    // Single word
    bus.m_ready = 1'b1; bus.in_vld = 1'b1; bus.in_data = 32'hDEADBEEF;
    cycle();
    check("single_ack", 64'(bus.in_ack), 64'(1));
    check("single_data", 64'(bus.m_data), 64'h0000_0000_DEAD_BEEF);
    check("single_count", 64'(count), 64'(1));
    bus.in_vld = 1'b0;
    cycle();
    check("single_ack_low", 64'(bus.in_ack), 64'(0));

    // Held valid: one ack only
    do_reset();
    bus.in_vld = 1'b1; bus.in_data = 32'h1234_5678;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (bus.in_ack) acks++;
    end
    check("held_acks", 64'(acks), 64'(1));
    check("held_count", 64'(count), 64'(1));
    check("held_valid", 64'(bus.m_valid), 64'(1));
    bus.in_vld = 1'b0;
    cycle();

    // Fill and backpressure
    do_reset();
    acks = 0;
    for (int w = 1; w <= 5; w++) begin
      bus.in_data = DATA_W'(w); bus.in_vld = 1'b1;
      for (int k = 0; k < 4; k++) begin
        cycle();
        if (bus.in_ack) begin acks++; break; end
      end
      if (w < 5) begin bus.in_vld = 1'b0; cycle(); end
    end
    check("fill_acks", 64'(acks), 64'(4));
    check("fill_full", 64'(full), 64'(1));
    bus.m_ready = 1'b1;
    cycle();
    check("pop_no_ack", 64'(bus.in_ack), 64'(0));
    bus.m_ready = 1'b0;
    cycle();
    check("late_ack", 64'(bus.in_ack), 64'(1));
    bus.in_vld = 1'b0;
    got.delete();
    bus.m_ready = 1'b1;
    repeat (6) cycle();
    check("drain_len", 64'(got.size()), 64'(4));
    for (int i = 0; i < 4 && i < got.size(); i++)
      check("drain_order", 64'(got[i]), 64'(i + 2));

    // Withdrawal sets sticky proto_err
    do_reset();
    for (int w = 0; w < 4; w++) send_word(DATA_W'($urandom));
    bus.in_vld = 1'b1; bus.in_data = 32'hBAD0_0001;
    cycle(); cycle();
    bus.in_vld = 1'b0;
    cycle();
    check("withdraw_err", 64'(proto_err), 64'(1));
    bus.m_ready = 1'b1;
    for (int w = 0; w < 3; w++) send_word(DATA_W'($urandom));
    check("err_sticky", 64'(proto_err), 64'(1));

    // Reset while in WAIT_LOW
    do_reset();
    bus.in_vld = 1'b1; bus.in_data = 32'h0000_005A;
    cycle();
    rst = 1'b1;
    cycle();
    check("wrst_ack", 64'(bus.in_ack), 64'(0));
    check("wrst_valid", 64'(bus.m_valid), 64'(0));
    check("wrst_count", 64'(count), 64'(0));
    rst = 1'b0;
    cycle();
    check("wrst_reack", 64'(bus.in_ack), 64'(1));
    check("wrst_count1", 64'(count), 64'(1));
    check("wrst_valid1", 64'(bus.m_valid), 64'(1));
    bus.in_vld = 1'b0;
    cycle();

    // Counter and pointer wrap with streaming drain
    do_reset();
    bus.m_ready = 1'b1;
    got.delete();
    sent.delete();
    for (int i = 0; i < 17; i++) begin
      sent.push_back(DATA_W'($urandom));
      send_word(sent[i]);
    end
    repeat (3) cycle();
    check("wrap_count", 64'(count), 64'(1));
    check("wrap_len", 64'(got.size()), 64'(17));
    for (int i = 0; i < 17 && i < got.size(); i++)
      check("wrap_order", 64'(got[i]), 64'(sent[i]));

    // Randomized traffic against the model
    do_reset();
    seen_ack = 0;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      bus.m_ready = ($urandom_range(0, 2) != 0);
      if (!bus.in_vld) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.in_vld = 1'b1; bus.in_data = DATA_W'($urandom); seen_ack = 0;
        end
      end else if (seen_ack && $urandom_range(0, 1) == 0) begin
        bus.in_vld = 1'b0;
      end else if (!seen_ack && $urandom_range(0, 15) == 0) begin
        bus.in_vld = 1'b0;
      end
      cycle();
      if (bus.in_ack) seen_ack = 1;
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
